ram_fifo_ctrl: RTL and testbench

//  Upstream controller for single_port_ram: turns a valid/ready byte stream into a FIFO stored in the RAM.
//  It arbitrates the single RAM port between stream writes and prefetch reads.
//  A one-entry output register presents the oldest byte to a valid/ready consumer.

---
 rtl/ram_fifo_ctrl.sv | 79 +++++++
 tb/tb_ram_fifo_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that stores a valid/ready byte stream in a single-port RAM
// and prefetches the oldest byte into a registered output stage.
module ram_fifo_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W:0]   FULL    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              rd_pending;
    logic              rd_issue;
    logic              wr_fire;
    logic              out_fire;

    // A read may only be issued when the output stage will be free on landing.
    always_comb begin
        rd_issue  = (ram_cnt != '0) && !rd_pending && (!out_valid || out_ready);
        in_ready  = !rst && (ram_cnt != FULL) && !rd_issue;
        wr_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        ram_we    = wr_fire;
        ram_addr  = wr_fire ? wr_ptr : rd_ptr;
        ram_wdata = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            rd_pending <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            level      <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                ram_cnt <= ram_cnt + CNT_ONE;
            end else if (rd_issue) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                ram_cnt <= ram_cnt - CNT_ONE;
            end
            rd_pending <= rd_issue;

            if (rd_pending) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (wr_fire && !out_fire) begin
                level <= level + CNT_ONE;
            end else if (!wr_fire && out_fire) begin
                level <= level - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural RAM plus a byte-queue reference model
// of the FIFO contents, driven with directed and randomized traffic.
module tb_ram_fifo_ctrl;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [ADDR_W:0]   level;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q [$];
    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;
    bit last_in_hs;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
    end

    // Inputs change at posedge+1; the model samples handshakes at the negedge.
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (int'(level) != q.size()) begin
                errors++; $display("FAIL level: got %0d expected %0d", level, q.size());
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stale_output: got %0h expected no valid byte", out_data);
                end else if (out_data !== q[0]) begin
                    errors++; $display("FAIL out_order: got %0h expected %0h", out_data, q[0]);
                end
            end
            if (q.size() == DEPTH + 1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready);
                end
            end
            last_in_hs = (in_valid === 1'b1) && (in_ready === 1'b1);
            checks++;
            if (ram_we !== last_in_hs) begin
                errors++; $display("FAIL ram_we: got %b expected %b", ram_we, last_in_hs);
            end
            if (out_valid === 1'b1 && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (last_in_hs) begin
                q.push_back(in_data);
                n_in++;
            end
        end else begin
            last_in_hs = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Asynchronous pulse mid-cycle, held through one rising edge.
    task automatic do_reset();
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b expected 0", ram_we); end
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (level !== '0) begin errors++; $display("FAIL post_rst_level: got %0d expected 0", level); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'd43; out_ready = 1'b1;
        #1;
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== '0) begin
            errors++; $display("FAIL single_c0: got we=%b addr=%0d expected we=1 addr=0", ram_we, ram_addr);
        end
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== '0) begin
            errors++; $display("FAIL single_c1: got we=%b addr=%0d expected we=0 addr=0", ram_we, ram_addr);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd43) begin
            errors++; $display("FAIL single_c3: got valid=%b data=%0d expected valid=1 data=43", out_valid, out_data);
        end
        step();
        checks++;
        if (level !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got level=%0d valid=%b expected 0/0", level, out_valid);
        end
    endtask

    task automatic test_fill();
        int idx = 0;
        int out0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            in_valid = (idx < 70);
            in_data  = 8'(idx);
            step();
            if (last_in_hs) idx++;
        end
        checks++;
        if (idx != 65) begin errors++; $display("FAIL fill_accepted: got %0d expected 65", idx); end
        checks++;
        if (level !== 7'd65) begin errors++; $display("FAIL fill_level: got %0d expected 65", level); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        out0 = n_out;
        for (int cyc = 0; cyc < 200; cyc++) step();
        checks++;
        if (n_out - out0 != 65) begin errors++; $display("FAIL fill_drain_count: got %0d expected 65", n_out - out0); end
        checks++;
        if (level !== '0) begin errors++; $display("FAIL fill_drain_level: got %0d expected 0", level); end
    endtask

    task automatic test_stream();
        int idx = 0;
        int out0 = n_out;
        for (int cyc = 0; cyc < 3000 && (n_out - out0) < 200; cyc++) begin
            in_valid  = (idx < 200) && ($urandom_range(0, 3) != 0);
            in_data   = 8'(idx);
            out_ready = ((cyc % 3) != 2);
            step();
            if (last_in_hs) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 200) begin errors++; $display("FAIL stream_in_count: got %0d expected 200", idx); end
        checks++;
        if (n_out - out0 != 200) begin errors++; $display("FAIL stream_out_count: got %0d expected 200", n_out - out0); end
    endtask

    task automatic test_issue_block();
        int acc = 0;
        out_ready = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 50 && acc < 4; cyc++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(acc);
            step();
            if (last_in_hs) acc++;
        end
        in_valid = 1'b0;
        repeat (4) step();
        in_valid = 1'b1; in_data = 8'hB0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 6'd1) begin
            errors++; $display("FAIL issue_cycle: got rdy=%b we=%b addr=%0d expected 0/0/1", in_ready, ram_we, ram_addr);
        end
        step();
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL issue_next_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 100 && q.size() < 10; cyc++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(100, 255));
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 7'd10) begin errors++; $display("FAIL mid_level: got %0d expected 10", level); end
        do_reset();
        checks++;
        if (level !== '0) begin errors++; $display("FAIL mid_post_rst_level: got %0d expected 0", level); end
        in_valid = 1'b1; in_data = 8'd62; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen || out_data !== 8'd62) begin
            errors++; $display("FAIL mid_first_out: got valid=%b data=%0d expected 1/62", seen, out_data);
        end
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_issue_block();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
